// File: rtl/pc_fetch_controller_if.sv
// Instruction-memory fetch channel: one outstanding request, req/ack handshake.
interface pc_fetch_controller_if #(
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned INSTR_W = 32;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/pc_fetch_controller.sv
// PC register and fetch sequencer: enable-based IDLE/WAIT/HALT FSM with
// redirect handling, merged halt sources and single-outstanding fetch.
module pc_fetch_controller #(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int unsigned       INSTR_STEP = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                halt_ext,
  input  logic                halt_int,
  input  logic                resume,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_addr,
  pc_fetch_controller_if.master imem,
  output logic [ADDR_W-1:0]   pc,
  output logic                instr_valid,
  output logic [31:0]         instr,
  output logic [ADDR_W-1:0]   instr_pc,
  output logic                halted
);

  localparam int unsigned INSTR_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_d;
  logic [INSTR_W-1:0]  instr_d;
  logic [ADDR_W-1:0]   instr_pc_d;
  logic                instr_valid_d;
  logic                halt_latch_q, halt_latch_d;
  logic                redirect_pending_q, redirect_pending_d;
  logic [ADDR_W-1:0]   redirect_target_q, redirect_target_d;
  logic                halt_any;

  // Latched internal halt participates only from the cycle after the pulse.
  assign halt_any       = halt_ext | halt_latch_q;
  assign halted         = (state_q == ST_HALT);
  assign imem.imem_req  = (state_q == ST_WAIT);
  assign imem.imem_addr = pc;

  always_comb begin
    state_d            = state_q;
    pc_d               = pc;
    instr_d            = instr;
    instr_pc_d         = instr_pc;
    instr_valid_d      = 1'b0;
    redirect_pending_d = redirect_pending_q;
    redirect_target_d  = redirect_target_q;
    halt_latch_d       = halt_latch_q;

    if (halt_int) begin
      halt_latch_d = 1'b1;
    end else if (resume) begin
      halt_latch_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (redirect_valid) pc_d = redirect_addr;
        if (halt_any) begin
          state_d = ST_HALT;
        end else if (!stall) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem.imem_ack) begin
          redirect_pending_d = 1'b0;
          state_d            = halt_any ? ST_HALT : ST_IDLE;
          // A redirect seen during the fetch discards the returned word.
          if (redirect_valid) begin
            pc_d = redirect_addr;
          end else if (redirect_pending_q) begin
            pc_d = redirect_target_q;
          end else begin
            pc_d          = pc + ADDR_W'(INSTR_STEP);
            instr_d       = imem.imem_rdata;
            instr_pc_d    = pc;
            instr_valid_d = 1'b1;
          end
        end else if (redirect_valid) begin
          redirect_pending_d = 1'b1;
          redirect_target_d  = redirect_addr;
        end
      end
      ST_HALT: begin
        if (redirect_valid) pc_d = redirect_addr;
        if (!halt_any) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= ST_IDLE;
      pc                 <= RESET_PC;
      instr              <= '0;
      instr_pc           <= '0;
      instr_valid        <= 1'b0;
      halt_latch_q       <= 1'b0;
      redirect_pending_q <= 1'b0;
      redirect_target_q  <= '0;
    end else begin
      state_q            <= state_d;
      pc                 <= pc_d;
      instr              <= instr_d;
      instr_pc           <= instr_pc_d;
      instr_valid        <= instr_valid_d;
      halt_latch_q       <= halt_latch_d;
      redirect_pending_q <= redirect_pending_d;
      redirect_target_q  <= redirect_target_d;
    end
  end

endmodule
